exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 opcode  input  7  instr[6:0] from the instruction register; sampled in DECODE.
REQ-005 rd  input  5  instr[11:7] destination register index.
REQ-006 br_taken  input  1  ALU compare result; sampled in EXEC for branch opcodes.
REQ-007 imem_req / imem_ack  output / input  1 / 1  instruction-fetch handshake.
REQ-008 dmem_req / dmem_we / dmem_ack  output / output / input  1 / 1 / 1  data-memory handshake.
REQ-009 ir_we, alu_en, rf_we, pc_we  output  1 each  register-file, IR, ALU and PC strobes.
REQ-010 pc_sel  output  2  next PC: 0 = pc+4, 1 = ALU result, 2 = pc+imm.
REQ-011 wb_sel  output  2  write-back source: 0 = ALU, 1 = memory, 2 = pc+4.
REQ-012 instret  output  CNT_W  count of retired instructions.
REQ-013 trap  output  1  sticky illegal-instruction flag.

Function
REQ-014 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP; exactly one is active per cycle.
REQ-015 FETCH: imem_req=1 until the cycle in which imem_ack=1.
  - ir_we=1 in that ack cycle; next state DECODE.
  - Zero-wait ack (ack in the first request cycle) is legal.
REQ-016 DECODE lasts exactly one cycle and classifies opcode as one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, or illegal.
  - Next state is EXEC, or TRAP per REQ-027.
REQ-017 EXEC: alu_en=1 for exactly one cycle.
  - LOAD/STORE go to MEM; all other classes go to WB.
  - For BRANCH, br_taken is registered in this cycle.
REQ-018 MEM: dmem_req=1, with dmem_we=1 for STORE only; both are held until dmem_ack=1, then next state is WB.
REQ-019 WB (one cycle): pc_we=1; instret increments by 1 (wraps modulo 2^CNT_W); next state FETCH.
REQ-020 WB, rf_we: asserted when rd!=0 and class is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM or OP; deasserted for BRANCH and STORE.
REQ-021 WB, wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
REQ-022 WB, pc_sel: 1 for JAL/JALR, 2 for a taken BRANCH, 0 otherwise.
REQ-023 Outside their stated states, imem_req, dmem_req, dmem_we, ir_we, alu_en, rf_we and pc_we are 0, and pc_sel/wb_sel are 0.
REQ-024 imem_ack outside FETCH and dmem_ack outside MEM are ignored.
REQ-025 Latency per instruction with zero-wait memory: 4 cycles for non-memory classes, 5 cycles for LOAD/STORE.

Reset
REQ-026 reset_n=0 at a rising edge, from any state including mid-handshake, takes effect at that same edge:
  - state goes to FETCH; instret and trap go to 0; all strobes and requests go to 0.
  - FETCH resumes on the first edge with reset_n=1.

Configuration
REQ-027 Macro SEQ_ILLEGAL_TRAP_EN, when defined: an illegal opcode in DECODE moves to TRAP.
  - In TRAP, trap=1, no strobes or requests assert, and the state is held until reset.
  - instret does not increment for the illegal instruction.
REQ-028 When SEQ_ILLEGAL_TRAP_EN is undefined, an illegal opcode is retired as a NOP:
  - DECODE, then EXEC, then WB, with rf_we=0 and pc_sel=0; instret increments.
  - trap is tied to 0 and the TRAP state is not implemented.

Verification
REQ-029 OP (0110011) with rd=5, zero-wait imem -> ir_we, alu_en and rf_we at cycles 1, 3 and 4 respectively; wb_sel=0, pc_sel=0, instret=1.
REQ-030 LOAD (0000011) with rd=3, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; then WB with rf_we=1, wb_sel=1.
REQ-031 BRANCH (1100011), br_taken=1 then br_taken=0 -> no rf_we in either; pc_sel=2 then pc_sel=0.
REQ-032 JAL (1101111) with rd=0 -> rf_we=0, pc_sel=1, wb_sel=2.
REQ-033 reset_n=0 during MEM of a STORE -> dmem_req=0 and instret=0 on the next edge; FETCH begins after release.
REQ-034 opcode 7'b1111111 -> macro defined: trap=1 held for 10 cycles with no imem_req; macro undefined: NOP retires and instret increments.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with handshaked memories.
// Optional feature: define SEQ_ILLEGAL_TRAP_EN to halt in a sticky TRAP state on illegal opcodes.
module exec_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             alu_en,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_IMM   = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_LINK  = 2'd2;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILL
  } cls_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    S_TRAP   = 3'd5
`endif
  } state_e;

  function automatic cls_e classify(input logic [6:0] op);
    cls_e c;
    case (op)
      OPC_LUI:    c = C_LUI;
      OPC_AUIPC:  c = C_AUIPC;
      OPC_JAL:    c = C_JAL;
      OPC_JALR:   c = C_JALR;
      OPC_BRANCH: c = C_BRANCH;
      OPC_LOAD:   c = C_LOAD;
      OPC_STORE:  c = C_STORE;
      OPC_OPIMM:  c = C_OPIMM;
      OPC_OP:     c = C_OP;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  // Classes that produce a register result; illegal NOPs, branches and stores do not.
  function automatic logic writes_rd(input cls_e c);
    return (c == C_LUI) || (c == C_AUIPC) || (c == C_JAL) || (c == C_JALR) ||
           (c == C_LOAD) || (c == C_OPIMM) || (c == C_OP);
  endfunction

  function automatic logic is_mem(input cls_e c);
    return (c == C_LOAD) || (c == C_STORE);
  endfunction

  state_e state, state_nxt;
  logic   active;
  cls_e   dec_cls;
  cls_e   cls_p1;
  logic   rd_nz_p1;
  logic   br_p2;

  assign dec_cls = classify(opcode);

  // State register and control counters; active stays low for the cycle after a reset edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      active  <= 1'b0;
      instret <= '0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
      if (state == S_WB)
        instret <= instret + CNT_W'(1);
    end
  end

  // Decode captures the instruction class and rd; exec captures the branch outcome.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) begin
      cls_p1   <= dec_cls;
      rd_nz_p1 <= |rd;
    end
    if (state == S_EXEC)
      br_p2 <= br_taken;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (active && imem_ack) state_nxt = S_DECODE;
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_DECODE: state_nxt = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      S_TRAP:   state_nxt = S_TRAP;
`else
      S_DECODE: state_nxt = S_EXEC;
`endif
      S_EXEC:   state_nxt = is_mem(cls_p1) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    wb_sel   = WB_ALU;
    case (state)
      S_FETCH: begin
        imem_req = active;
        ir_we    = active & imem_ack;
      end
      S_EXEC: alu_en = 1'b1;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_p1 == C_STORE);
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = rd_nz_p1 & writes_rd(cls_p1);
        if (cls_p1 == C_LOAD)
          wb_sel = WB_MEM;
        else if (cls_p1 == C_JAL || cls_p1 == C_JALR)
          wb_sel = WB_LINK;
        if (cls_p1 == C_JAL || cls_p1 == C_JALR)
          pc_sel = PC_ALU;
        else if (cls_p1 == C_BRANCH && br_p2)
          pc_sel = PC_IMM;
      end
      default: ;
    endcase
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  assign trap = (state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized scoreboard bench for exec_sequencer: stimulus pushes expected retirements, a monitor checks each WB.
// Honors SEQ_ILLEGAL_TRAP_EN the same way the design does.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        br_taken;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        ir_we, alu_en, rf_we, pc_we;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;
  logic        trap;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rf;
    logic [1:0] wb;
    logic [1:0] pc;
    int         lat;
    int         dreq;
    int         dwe;
    int         icnt;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt = 0;

  exec_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .rd(rd), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .alu_en(alu_en), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .wb_sel(wb_sel), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference behaviour of one instruction, straight from the opcode table.
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] r, input logic tk,
                                 input int dw, input int cnt);
    exp_t e;
    logic mem, st;
    e.rf = 1'b0; e.wb = 2'd0; e.pc = 2'd0; mem = 1'b0; st = 1'b0;
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: e.rf = (r != 0);
      7'b1101111, 7'b1100111: begin e.rf = (r != 0); e.wb = 2'd2; e.pc = 2'd1; end
      7'b1100011: e.pc = tk ? 2'd2 : 2'd0;
      7'b0000011: begin e.rf = (r != 0); e.wb = 2'd1; mem = 1'b1; end
      7'b0100011: begin mem = 1'b1; st = 1'b1; end
      default: ;
    endcase
    e.lat  = mem ? 4 + dw : 3;
    e.dreq = mem ? dw + 1 : 0;
    e.dwe  = st ? dw + 1 : 0;
    e.icnt = cnt;
    return e;
  endfunction

  // Runs one instruction to completion; ack lines carry noise whenever the DUT must ignore them.
  task automatic run_instr(input logic [6:0] op, input logic [4:0] r, input logic tk,
                           input int iw, input int dw);
    logic mem;
    mem = (op == 7'b0000011) || (op == 7'b0100011);
    exp_q.push_back(model(op, r, tk, dw, model_cnt));
    model_cnt++;
    opcode = op; rd = r; br_taken = tk;
    for (int k = 0; k < iw; k++) begin
      imem_ack = 1'b0; dmem_ack = 1'($urandom_range(0, 1));
      step();
    end
    imem_ack = 1'b1; dmem_ack = 1'($urandom_range(0, 1));
    step();
    imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
    step();
    imem_ack = 1'($urandom_range(0, 1)); dmem_ack = mem ? 1'b0 : 1'($urandom_range(0, 1));
    br_taken = tk;
    step();
    br_taken = 1'($urandom_range(0, 1));
    if (mem) begin
      for (int k = 0; k < dw; k++) begin
        imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'b0;
        step();
      end
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'b1;
      step();
    end
    imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
    step();
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  // Monitor: tracks one instruction window from ir_we to pc_we and scores it at WB.
  initial begin
    int cyc = 0, alu = 0, dreq = 0, dwe = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (ir_we) begin cyc = 0; alu = 0; dreq = 0; dwe = 0; end
        else cyc++;
        if (alu_en) alu++;
        if (dmem_req) dreq++;
        if (dmem_we) dwe++;
        if (!pc_we) begin
          check("idle_wb_fields", {rf_we, pc_sel, wb_sel}, 0);
        end else if (exp_q.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rf_we", rf_we, e.rf);
          check("wb_sel", wb_sel, e.wb);
          check("pc_sel", pc_sel, e.pc);
          check("instret_at_wb", instret, e.icnt);
          check("latency", cyc, e.lat);
          check("alu_en_pulses", alu, 1);
          check("dmem_req_cycles", dreq, e.dreq);
          check("dmem_we_cycles", dwe, e.dwe);
        end
      end
    end
  end

  initial begin
    logic [6:0] legal [9];
    logic [6:0] op;
    legal = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    opcode = 7'b0110011; rd = 5'd0; br_taken = 1'b0;
    step(); step();
    imem_ack = 1'b1;
    step();
    check("rst_imem_req", imem_req, 0);
    check("rst_ir_we", ir_we, 0);
    check("rst_instret", instret, 0);
    check("rst_trap", trap, 0);
    imem_ack = 1'b0;
    reset_n = 1'b1;
    step();
    check("fetch_after_release", imem_req, 1);

    run_instr(7'b0110011, 5'd5, 1'b0, 0, 0);
    run_instr(7'b0000011, 5'd3, 1'b0, 0, 3);
    run_instr(7'b1100011, 5'd7, 1'b1, 0, 0);
    run_instr(7'b1100011, 5'd7, 1'b0, 1, 0);
    run_instr(7'b1101111, 5'd0, 1'b0, 0, 0);
    check("instret_after_directed", instret, 5);

    for (int n = 0; n < 200; n++) begin
      op = legal[$urandom_range(0, 8)];
`ifndef SEQ_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) begin
        op = 7'($urandom);
        if (is_legal(op)) op = 7'b1111111;
      end
`endif
      run_instr(op, 5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
    end
    check("queue_drained", exp_q.size(), 0);
    check("instret_after_random", instret, model_cnt);

    // Reset in the middle of a STORE data handshake.
    opcode = 7'b0100011; rd = 5'd9; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    step();
    check("store_mem_req", dmem_req, 1);
    check("store_mem_we", dmem_we, 1);
    reset_n = 1'b0;
    step();
    check("rst_mid_store_dmem_req", dmem_req, 0);
    check("rst_mid_store_dmem_we", dmem_we, 0);
    check("rst_mid_store_instret", instret, 0);
    check("rst_mid_store_imem_req", imem_req, 0);
    reset_n = 1'b1;
    model_cnt = 0;
    step();
    check("fetch_after_store_reset", imem_req, 1);
    run_instr(7'b0110011, 5'd1, 1'b0, 0, 0);
    check("instret_post_reset", instret, 1);

`ifdef SEQ_ILLEGAL_TRAP_EN
    opcode = 7'b1111111; rd = 5'd4; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      step();
      check("trap_held", trap, 1);
      check("trap_no_imem_req", imem_req, 0);
      check("trap_no_strobes", {ir_we, alu_en, pc_we, rf_we, dmem_req}, 0);
    end
    check("trap_instret", instret, 1);
`else
    run_instr(7'b1111111, 5'd4, 1'b0, 0, 0);
    check("illegal_nop_trap", trap, 0);
    check("illegal_nop_instret", instret, 2);
`endif
    step();
    check("queue_drained_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
